adc_cassette_slicer: RTL

Parametrised cassette-input slicer for the ADC tape path. It takes time-stamped ADC samples from the ltc2308 interface and keeps a power-of-two running-average baseline in a circular RAM. It converts the signal to a 1-bit cassette level with programmable hysteresis and polarity, and measures the sample count between level transitions for future fast-load decoders. It sits between the ADC block (CLK_50M domain) and the `casdout` input of `dragoncoco`, and replaces the fixed 512-tap shift-register averager with a generalised, overflow-safe unit.

---
 rtl/adc_cassette_slicer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/adc_cassette_slicer.sv
// Cassette-input slicer: running-average baseline over a circular RAM, hysteresis
// slicing to a 1-bit level, and edge-to-edge period measurement.
module adc_cassette_slicer #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 9,
  parameter int PER_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_tgl,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] hyst,
  input  logic              invert,
  input  logic              clear,
  output logic              cas_bit,
  output logic [DATA_W-1:0] avg,
  output logic              valid,
  output logic              edge_pulse,
  output logic [PER_W-1:0]  period,
  output logic              period_stb,
  output logic              overrun
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int TOT_W = DATA_W + AVG_LOG2;
  localparam int CMP_W = DATA_W + 2;

  typedef enum logic {FILL, RUN} state_t;
  state_t state, state_next;

  logic                    tgl_q;
  logic                    busy;
  logic                    raw;
  logic                    raw_next;
  logic                    edge_q;
  logic                    running;
  logic [DATA_W-1:0]       sample_q;
  logic [DATA_W-1:0]       rd_data;
  logic [DATA_W-1:0]       old;
  logic [AVG_LOG2-1:0]     wr_ptr;
  logic [TOT_W-1:0]        total;
  logic [TOT_W-1:0]        total_next;
  logic [PER_W-1:0]        pcnt;
  logic [PER_W-1:0]        pcnt_inc;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic                    toggle;
  logic                    accept;
  logic                    stage_b;
  logic                    slice_en;
  logic signed [CMP_W-1:0] s_cmp;
  logic signed [CMP_W-1:0] lo_cmp;
  logic signed [CMP_W-1:0] hi_cmp;

  assign toggle   = sample_tgl != tgl_q;
  assign accept   = toggle && !busy && !clear;
  assign stage_b  = busy && !clear;
  assign slice_en = stage_b && running;

  // Tracks the toggle even during reset so a stale level is never taken as a sample.
  always_ff @(posedge clk) begin
    tgl_q <= sample_tgl;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rd_data <= mem[wr_ptr];
    end
    if (stage_b) begin
      mem[wr_ptr] <= sample_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = FILL;
    end else if (stage_b && (state == FILL) && (wr_ptr == '1)) begin
      state_next = RUN;
    end
  end

  always_comb begin
    running = (state == RUN);
    valid   = running;
  end

  // Stale RAM contents are masked while the window refills.
  always_comb begin
    old        = running ? rd_data : '0;
    total_next = total - TOT_W'(old) + TOT_W'(sample_q);
    pcnt_inc   = (pcnt == '1) ? pcnt : pcnt + 1'b1;
    s_cmp      = $signed({2'b00, sample_q});
    lo_cmp     = $signed({2'b00, avg}) - $signed({2'b00, hyst});
    hi_cmp     = $signed({2'b00, avg}) + $signed({2'b00, hyst});
    raw_next   = raw;
    if (slice_en) begin
      if (s_cmp < lo_cmp) begin
        raw_next = 1'b1;
      end else if (s_cmp > hi_cmp) begin
        raw_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      sample_q <= '0;
      total    <= '0;
      wr_ptr   <= '0;
      avg      <= '0;
      raw      <= 1'b0;
      pcnt     <= '0;
      period   <= '0;
      edge_q   <= 1'b0;
      overrun  <= 1'b0;
    end else if (clear) begin
      busy    <= 1'b0;
      total   <= '0;
      wr_ptr  <= '0;
      avg     <= '0;
      raw     <= 1'b0;
      pcnt    <= '0;
      period  <= '0;
      edge_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      edge_q <= 1'b0;
      if (accept) begin
        sample_q <= sample;
        busy     <= 1'b1;
      end else if (toggle && busy) begin
        overrun <= 1'b1;
      end
      if (stage_b) begin
        busy   <= 1'b0;
        total  <= total_next;
        wr_ptr <= wr_ptr + 1'b1;
        avg    <= total_next[TOT_W-1:AVG_LOG2];
        raw    <= raw_next;
        if (running) begin
          if (raw_next != raw) begin
            edge_q <= 1'b1;
            period <= pcnt_inc;
            pcnt   <= '0;
          end else begin
            pcnt <= pcnt_inc;
          end
        end
      end
    end
  end

  assign cas_bit    = raw ^ invert;
  assign edge_pulse = edge_q;
  assign period_stb = edge_q;

endmodule
